display_arbiter: RTL and testbench

Time-slicing arbiter that shares the single 4-digit seven-segment display among up to N_REQ BCD value sources, such as the up/down counter, a status/error code and a debug value. It sits between the sources and display_7_seg and drives that module's units/tens/hundreds/thousands inputs. Ownership is granted round-robin with a guaranteed minimum hold time, so a human can read each value before it is replaced.

---
 rtl/display_arb_pkg.sv | 18 +
 rtl/rr_pick.sv | 27 ++
 rtl/display_arbiter.sv | 127 ++++++++++++
 tb/tb_display_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/display_arb_pkg.sv
// Shared types and helpers for the display time-slicing arbiter.
package display_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OWN    = 2'd1,
        LINGER = 2'd2
    } arb_state_t;

    localparam int BCD_W   = 16;
    localparam int DIGIT_W = 4;

    // Bits needed to hold 0..n-1, never less than one so a port always exists.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester after last_owner, wrapping,
// with last_owner itself examined last.
module rr_pick #(
    parameter int N_REQ = 3,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last_owner,
    output logic             valid,
    output logic [IDX_W-1:0] index
);

    always_comb begin
        int cand;
        cand  = 0;
        valid = 1'b0;
        index = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = (int'(last_owner) + k) % N_REQ;
            if (!valid && req[cand]) begin
                valid = 1'b1;
                index = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/display_arbiter.sv
// Shares one 4-digit seven-segment display among N_REQ BCD sources using
// round-robin ownership with a guaranteed minimum hold time.
module display_arbiter
    import display_arb_pkg::*;
#(
    parameter int N_REQ       = 3,
    parameter int HOLD_CYCLES = 50_000_000
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic [N_REQ-1:0]         req,
    input  logic [BCD_W*N_REQ-1:0]   bcd_in,
    output logic [N_REQ-1:0]         grant,
    output logic [DIGIT_W-1:0]       units,
    output logic [DIGIT_W-1:0]       tens,
    output logic [DIGIT_W-1:0]       hundreds,
    output logic [DIGIT_W-1:0]       thousands,
    output logic                     blank,
    output logic                     switch_pulse
);

    localparam int IDX_W = idx_width(N_REQ);
    localparam int CNT_W = idx_width(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    arb_state_t       state;
    logic [IDX_W-1:0] owner;
    logic [CNT_W-1:0] hold_cnt;

    logic             pick_valid;
    logic [IDX_W-1:0] pick_idx;
    logic             hold_done;
    logic             owner_req;
    logic             other_pending;
    logic [BCD_W-1:0] owner_bcd;
    logic [BCD_W-1:0] pick_bcd;

    logic take_new;
    logic go_idle;
    logic go_linger;
    logic resume;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req        (req),
        .last_owner (owner),
        .valid      (pick_valid),
        .index      (pick_idx)
    );

    assign hold_done     = (hold_cnt == HOLD_LAST);
    assign owner_req     = req[owner];
    assign owner_bcd     = bcd_in[BCD_W*int'(owner) +: BCD_W];
    assign pick_bcd      = bcd_in[BCD_W*int'(pick_idx) +: BCD_W];
    // The owner is searched last, so a pick equal to it means nobody else waits.
    assign other_pending = pick_valid && (pick_idx != owner);

    always_comb begin
        take_new  = 1'b0;
        go_idle   = 1'b0;
        go_linger = 1'b0;
        resume    = 1'b0;
        case (state)
            IDLE: take_new = pick_valid;
            OWN: begin
                if (!owner_req && !hold_done)
                    go_linger = 1'b1;
                else if (hold_done && other_pending)
                    take_new = 1'b1;
                else if (hold_done && !owner_req)
                    go_idle = 1'b1;
            end
            LINGER: begin
                if (owner_req) begin
                    resume = 1'b1;
                end else if (hold_done) begin
                    take_new = pick_valid;
                    go_idle  = !pick_valid;
                end
            end
            default: go_idle = 1'b1;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state        <= IDLE;
            owner        <= IDX_W'(N_REQ - 1);
            grant        <= '0;
            hold_cnt     <= '0;
            {thousands, hundreds, tens, units} <= '0;
            blank        <= 1'b1;
            switch_pulse <= 1'b0;
        end else begin
            switch_pulse <= take_new;
            if (take_new) begin
                state    <= OWN;
                owner    <= pick_idx;
                grant    <= N_REQ'(1) << pick_idx;
                hold_cnt <= '0;
                blank    <= 1'b0;
                {thousands, hundreds, tens, units} <= pick_bcd;
            end else if (go_idle) begin
                state <= IDLE;
                grant <= '0;
                blank <= 1'b1;
            end else begin
                if (state != IDLE && !hold_done)
                    hold_cnt <= hold_cnt + CNT_W'(1);
                // Lingering keeps the digits frozen; resuming keeps the hold count.
                if (go_linger) begin
                    state <= LINGER;
                    grant <= '0;
                end else if (resume) begin
                    state <= OWN;
                    grant <= N_REQ'(1) << owner;
                    {thousands, hundreds, tens, units} <= owner_bcd;
                end else if (state == OWN) begin
                    {thousands, hundreds, tens, units} <= owner_bcd;
                end
            end
        end
    end

endmodule

// File: tb/tb_display_arbiter.sv
// Directed self-checking bench for display_arbiter (N_REQ=3, HOLD_CYCLES=4 and 1).
module tb_display_arbiter;

    logic        CLK;
    logic        RST_N;
    logic [2:0]  req;
    logic [47:0] bcd;
    logic [2:0]  grant;
    logic [3:0]  units, tens, hundreds, thousands;
    logic        blank;
    logic        switch_pulse;

    logic [2:0]  req1;
    logic [47:0] bcd1;
    logic [2:0]  grant1;
    logic [3:0]  units1, tens1, hundreds1, thousands1;
    logic        blank1;
    logic        switch_pulse1;

    int checks = 0;
    int errors = 0;

    wire [15:0] digits  = {thousands, hundreds, tens, units};
    wire [15:0] digits1 = {thousands1, hundreds1, tens1, units1};

    display_arbiter #(.N_REQ(3), .HOLD_CYCLES(4)) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .req          (req),
        .bcd_in       (bcd),
        .grant        (grant),
        .units        (units),
        .tens         (tens),
        .hundreds     (hundreds),
        .thousands    (thousands),
        .blank        (blank),
        .switch_pulse (switch_pulse)
    );

    display_arbiter #(.N_REQ(3), .HOLD_CYCLES(1)) dut1 (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .req          (req1),
        .bcd_in       (bcd1),
        .grant        (grant1),
        .units        (units1),
        .tens         (tens1),
        .hundreds     (hundreds1),
        .thousands    (thousands1),
        .blank        (blank1),
        .switch_pulse (switch_pulse1)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        req   = 3'b000;
        tick();
        RST_N = 1'b1;
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        req   = 3'b000;
        bcd   = '0;
        req1  = 3'b000;
        bcd1  = {16'h0003, 16'h0002, 16'h0001};
        tick();
        tick();
        checks++;
        if ({grant, blank, switch_pulse, digits} !== {3'b000, 1'b1, 1'b0, 16'h0000}) begin
            errors++;
            $display("[TB] FAIL reset_state: got grant=%b blank=%b pulse=%b digits=%h, expected 000 1 0 0000",
                     grant, blank, switch_pulse, digits);
        end
        RST_N = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        bcd[15:0] = 16'h1234;
        req = 3'b001;
        tick();
        checks++;
        if ({grant, blank, switch_pulse, digits} !== {3'b001, 1'b0, 1'b1, 16'h1234}) begin
            errors++;
            $display("[TB] FAIL single_grant: got grant=%b blank=%b pulse=%b digits=%h, expected 001 0 1 1234",
                     grant, blank, switch_pulse, digits);
        end
        bcd[15:0] = 16'h1235;
        tick();
        checks++;
        if ({grant, switch_pulse, digits} !== {3'b001, 1'b0, 16'h1235}) begin
            errors++;
            $display("[TB] FAIL live_tracking: got grant=%b pulse=%b digits=%h, expected 001 0 1235",
                     grant, switch_pulse, digits);
        end
    endtask

    task automatic test_rotation();
        logic [2:0] exp_grant;
        logic       exp_pulse;
        do_reset();
        bcd = {16'h0003, 16'h0002, 16'h0001};
        req = 3'b111;
        for (int c = 0; c < 13; c++) begin
            tick();
            exp_grant = 3'b001 << ((c / 4) % 3);
            exp_pulse = (c % 4 == 0);
            checks++;
            if ({grant, switch_pulse, units} !== {exp_grant, exp_pulse, 4'(((c / 4) % 3) + 1)}) begin
                errors++;
                $display("[TB] FAIL rotation_c%0d: got grant=%b pulse=%b units=%h, expected %b %b %0d",
                         c, grant, switch_pulse, units, exp_grant, exp_pulse, ((c / 4) % 3) + 1);
            end
        end
    endtask

    task automatic test_linger();
        do_reset();
        bcd = {16'h0000, 16'h0000, 16'h0042};
        req = 3'b001;
        tick();
        tick();
        req = 3'b000;
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if ({grant, blank, switch_pulse, digits} !== {3'b000, 1'b0, 1'b0, 16'h0042}) begin
                errors++;
                $display("[TB] FAIL linger_c%0d: got grant=%b blank=%b pulse=%b digits=%h, expected 000 0 0 0042",
                         c, grant, blank, switch_pulse, digits);
            end
        end
        tick();
        checks++;
        if ({grant, blank, switch_pulse, digits} !== {3'b000, 1'b1, 1'b0, 16'h0042}) begin
            errors++;
            $display("[TB] FAIL linger_to_idle: got grant=%b blank=%b pulse=%b digits=%h, expected 000 1 0 0042",
                     grant, blank, switch_pulse, digits);
        end

        // Resume from linger keeps the running hold count.
        do_reset();
        req = 3'b001;
        tick();
        tick();
        req = 3'b000;
        tick();
        req = 3'b011;
        tick();
        checks++;
        if ({grant, blank, switch_pulse} !== {3'b001, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL linger_resume: got grant=%b blank=%b pulse=%b, expected 001 0 0",
                     grant, blank, switch_pulse);
        end
        tick();
        checks++;
        if ({grant, switch_pulse} !== {3'b010, 1'b1}) begin
            errors++;
            $display("[TB] FAIL resume_hold_kept: got grant=%b pulse=%b, expected 010 1", grant, switch_pulse);
        end
    endtask

    task automatic test_drop_waiter();
        do_reset();
        req = 3'b010;
        tick();
        checks++;
        if (grant !== 3'b010) begin
            errors++;
            $display("[TB] FAIL waiter_first: got grant=%b, expected 010", grant);
        end
        req = 3'b110;
        tick();
        tick();
        req = 3'b100;
        tick();
        checks++;
        if ({grant, blank, switch_pulse} !== {3'b000, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL waiter_gap: got grant=%b blank=%b pulse=%b, expected 000 0 0",
                     grant, blank, switch_pulse);
        end
        tick();
        checks++;
        if ({grant, blank, switch_pulse} !== {3'b100, 1'b0, 1'b1}) begin
            errors++;
            $display("[TB] FAIL waiter_switch: got grant=%b blank=%b pulse=%b, expected 100 0 1",
                     grant, blank, switch_pulse);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        bcd = {16'h0000, 16'h0000, 16'h1234};
        req = 3'b001;
        tick();
        tick();
        #2;
        RST_N = 1'b0;
        #1;
        checks++;
        if ({grant, blank, digits} !== {3'b000, 1'b1, 16'h0000}) begin
            errors++;
            $display("[TB] FAIL async_reset: got grant=%b blank=%b digits=%h, expected 000 1 0000",
                     grant, blank, digits);
        end
        tick();
        req   = 3'b110;
        RST_N = 1'b1;
        tick();
        checks++;
        if ({grant, switch_pulse} !== {3'b010, 1'b1}) begin
            errors++;
            $display("[TB] FAIL post_reset_pick: got grant=%b pulse=%b, expected 010 1", grant, switch_pulse);
        end
    endtask

    task automatic test_hold1();
        logic [2:0]  exp_grant;
        logic [15:0] exp_digits;
        req1 = 3'b101;
        for (int c = 0; c < 6; c++) begin
            tick();
            exp_grant  = (c % 2 == 0) ? 3'b001 : 3'b100;
            exp_digits = (c % 2 == 0) ? 16'h0001 : 16'h0003;
            checks++;
            if ({grant1, switch_pulse1, blank1, digits1} !== {exp_grant, 1'b1, 1'b0, exp_digits}) begin
                errors++;
                $display("[TB] FAIL hold1_c%0d: got grant=%b pulse=%b blank=%b digits=%h, expected %b 1 0 %h",
                         c, grant1, switch_pulse1, blank1, digits1, exp_grant, exp_digits);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_rotation();
        test_linger();
        test_drop_waiter();
        test_async_reset();
        test_hold1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
